mips_run_ctrl: RTL and testbench

//   Run controller for the mips core: sequences the core reset, counts executed cycles,

---
 rtl/mips_run_ctrl.sv | 148 ++++++++++++++
 tb/tb_mips_run_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_ctrl.sv
// Run controller for the mips core: sequences core reset, counts RUN cycles,
// detects program end (PC self-loop) and enforces a watchdog timeout.
module mips_run_ctrl #(
    parameter int RST_CYCLES  = 4,
    parameter int HALT_REPEAT = 2,
    parameter int TIMEOUT     = 100000,
    parameter int CNT_W       = 32,
    parameter int PC_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    // start is a single-cycle request, honoured only in IDLE, HALTED and TMO;
    // there is no ready/acknowledge, a pulse in RST_HOLD or RUN is dropped.
    input  logic             start,
    input  logic [PC_W-1:0]  pc,
    output logic             core_reset,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [2:0]       dbg_state
);

    localparam int R_EFF  = (RST_CYCLES < 1) ? 1 : RST_CYCLES;
    localparam int HOLD_W = $clog2(R_EFF + 1);
    localparam int SAME_W = $clog2(HALT_REPEAT + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(R_EFF - 1);
    localparam logic [SAME_W-1:0] SAME_HALT = SAME_W'(HALT_REPEAT);
    localparam logic [CNT_W-1:0]  CNT_TMO   = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HOLD   = 3'd1,
        S_RUN    = 3'd2,
        S_HALTED = 3'd3,
        S_TMO    = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
    logic [SAME_W-1:0] same_cnt, same_cnt_n;
    logic [PC_W-1:0]   last_pc, last_pc_n;
    logic              first_run, first_run_n;
    logic              core_reset_n, running_n, done_n, timeout_n;
    logic [CNT_W-1:0]  cycle_cnt_n;
    logic [CNT_W-1:0]  cnt_inc;
    logic [SAME_W-1:0] same_upd;

    assign dbg_state = state;

    always_comb begin
        state_n      = state;
        hold_cnt_n   = hold_cnt;
        same_cnt_n   = same_cnt;
        last_pc_n    = last_pc;
        first_run_n  = first_run;
        core_reset_n = core_reset;
        running_n    = running;
        done_n       = done;
        timeout_n    = timeout;
        cycle_cnt_n  = cycle_cnt;
        cnt_inc      = cycle_cnt + CNT_W'(1);
        same_upd     = '0;

        case (state)
            S_IDLE, S_HALTED, S_TMO: begin
                core_reset_n = 1'b1;
                running_n    = 1'b0;
                if (start) begin
                    state_n     = S_HOLD;
                    hold_cnt_n  = '0;
                    cycle_cnt_n = '0;
                    done_n      = 1'b0;
                    timeout_n   = 1'b0;
                end
            end

            S_HOLD: begin
                core_reset_n = 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    state_n      = S_RUN;
                    core_reset_n = 1'b0;
                    running_n    = 1'b1;
                    first_run_n  = 1'b1;
                end else begin
                    hold_cnt_n = hold_cnt + HOLD_W'(1);
                end
            end

            S_RUN: begin
                cycle_cnt_n = cnt_inc;
                last_pc_n   = pc;
                first_run_n = 1'b0;
                // The first RUN cycle only primes last_pc; comparing starts next cycle.
                if (!first_run && (pc == last_pc)) begin
                    same_upd = same_cnt + SAME_W'(1);
                end
                same_cnt_n = same_upd;
                // Halt is tested first so it wins when both land on one edge.
                if (same_upd == SAME_HALT) begin
                    state_n      = S_HALTED;
                    done_n       = 1'b1;
                    core_reset_n = 1'b1;
                    running_n    = 1'b0;
                end else if (cnt_inc == CNT_TMO) begin
                    state_n      = S_TMO;
                    timeout_n    = 1'b1;
                    core_reset_n = 1'b1;
                    running_n    = 1'b0;
                end
            end

            default: begin
                state_n      = S_IDLE;
                core_reset_n = 1'b1;
                running_n    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            hold_cnt   <= '0;
            same_cnt   <= '0;
            last_pc    <= '0;
            first_run  <= 1'b0;
            core_reset <= 1'b1;
            running    <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            cycle_cnt  <= '0;
        end else begin
            state      <= state_n;
            hold_cnt   <= hold_cnt_n;
            same_cnt   <= same_cnt_n;
            last_pc    <= last_pc_n;
            first_run  <= first_run_n;
            core_reset <= core_reset_n;
            running    <= running_n;
            done       <= done_n;
            timeout    <= timeout_n;
            cycle_cnt  <= cycle_cnt_n;
        end
    end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: directed scenarios followed by random start/reset/pc
// traffic, all checked against a history-based run model.
module tb_mips_run_ctrl;

    localparam int RST = 4;
    localparam int HR  = 2;
    localparam int TMO = 20;
    localparam int CW  = 16;
    localparam int PW  = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [PW-1:0] pc;
    logic          core_reset, running, done, timeout;
    logic [CW-1:0] cycle_cnt;
    logic [2:0]    dbg_state;

    int errors = 0;
    int checks = 0;

    logic [CW-1:0] exp_q[$];

    // reference model: a run is a release edge plus the list of pcs seen in RUN
    bit            m_seq;
    bit            m_running;
    bit            m_done;
    bit            m_tmo;
    int            m_now;
    int            m_release;
    int            m_cnt;
    logic [PW-1:0] pcs[$];
    bit            prev_running;
    bit            reset_seen;

    mips_run_ctrl #(
        .RST_CYCLES (RST),
        .HALT_REPEAT(HR),
        .TIMEOUT    (TMO),
        .CNT_W      (CW),
        .PC_W       (PW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pc        (pc),
        .core_reset(core_reset),
        .running   (running),
        .done      (done),
        .timeout   (timeout),
        .cycle_cnt (cycle_cnt),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit halt_seen();
        int n = pcs.size();
        if (n < HR + 1) return 1'b0;
        for (int k = 1; k <= HR; k++) begin
            if (pcs[n-1-k] != pcs[n-1]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic end_run();
        m_running = 1'b0;
        m_seq     = 1'b0;
        exp_q.push_back(CW'(m_cnt));
    endtask

    task automatic model_edge(input bit r, input bit s, input logic [PW-1:0] p);
        m_now++;
        if (r) begin
            m_seq = 0; m_running = 0; m_done = 0; m_tmo = 0; m_cnt = 0;
            pcs.delete();
        end else if (!m_seq && s) begin
            m_seq = 1; m_running = 0; m_done = 0; m_tmo = 0; m_cnt = 0;
            m_release = m_now + ((RST < 1) ? 1 : RST);
            pcs.delete();
        end else if (m_seq && !m_running && m_now == m_release) begin
            m_running = 1;
        end else if (m_running) begin
            pcs.push_back(p);
            m_cnt = pcs.size();
            if (halt_seen()) begin
                m_done = 1;
                end_run();
            end else if (m_cnt == TMO) begin
                m_tmo = 1;
                end_run();
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        reset_seen = reset;
        model_edge(reset, start, pc);
        #1;
        check("running", running, m_running);
        check("core_reset", core_reset, !m_running);
        check("done", done, m_done);
        check("timeout", timeout, m_tmo);
        check("cycle_cnt", cycle_cnt, CW'(m_cnt));
        if (prev_running && !running && !reset_seen) begin
            if (exp_q.size() == 0) check("run_end_queue", 1, 0);
            else check("run_end_cnt", cycle_cnt, exp_q.pop_front());
        end
        if (reset_seen) exp_q.delete();
        prev_running = running;
    endtask

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        m_seq = 0; m_running = 0; m_done = 0; m_tmo = 0;
        m_now = 0; m_release = 0; m_cnt = 0; prev_running = 0;
        reset = 1'b1; start = 1'b0; pc = '0;

        // reset then idle
        repeat (3) step();
        reset = 1'b0;
        repeat (10) step();
        check("idle_core_reset", core_reset, 1);
        check("idle_cycle_cnt", cycle_cnt, 0);

        // sequence timing: core_reset held through edge 3, released at edge 4
        start_run();
        repeat (3) step();
        check("hold_core_reset", core_reset, 1);
        step();
        check("release_running", running, 1);
        check("release_core_reset", core_reset, 0);

        // halt on pc self-loop
        pc = 32'h3000; step();
        pc = 32'h3004; step();
        pc = 32'h3008; repeat (3) step();
        check("halt_done", done, 1);
        check("halt_cnt", cycle_cnt, 5);
        check("halt_core_reset", core_reset, 1);

        // restart from HALTED
        start_run();
        check("restart_done_clr", done, 0);
        repeat (RST) step();
        pc = 32'h100; step();
        check("restart_cnt", cycle_cnt, 1);

        // watchdog: pc always advancing
        for (int i = 1; i < TMO; i++) begin
            pc = pc + 4; step();
        end
        check("tmo_flag", timeout, 1);
        check("tmo_cnt", cycle_cnt, TMO);
        check("tmo_done", done, 0);

        // halt and timeout on the same edge: halt wins
        start_run();
        repeat (RST) step();
        pc = 32'h4000;
        for (int i = 1; i <= TMO; i++) begin
            if (i > 1 && i <= TMO - HR) pc = pc + 4;
            step();
        end
        check("sim_done", done, 1);
        check("sim_tmo", timeout, 0);
        check("sim_cnt", cycle_cnt, TMO);

        // abort mid-RUN
        start_run();
        repeat (RST + 3) begin
            pc = pc + 4; step();
        end
        reset = 1'b1; step();
        check("abort_running", running, 0);
        check("abort_core_reset", core_reset, 1);
        check("abort_cnt", cycle_cnt, 0);
        reset = 1'b0;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 2) != 0) pc = $urandom() & 32'hffff_fffc;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
